// File: rtl/exec_sequencer_pkg.sv
// Shared opcode constants, unit-class and sequencer state encodings for the execution sequencer.
package exec_pkg;

    localparam logic [3:0] OP_MOVI = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_MOV,
        CL_JMP,
        CL_HALT,
        CL_ILL
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_HALTED,
        ST_ERR
    } state_e;

endpackage

// File: rtl/exec_sequencer_if.sv
// Fetch/unit handshake bundle between the execution sequencer (master) and its environment (slave).
interface exec_sequencer_if #(
    parameter int IW = 16
);
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic          mov_done;
    logic          alu_done;
    logic          jmp_done;
    logic          resume;
    logic          fetch_req;
    logic          mov_str;
    logic          alu_str;
    logic          jmp_str;
    logic [3:0]    op_code;
    logic [IW-1:0] instr_q;
    logic          busy;
    logic          halted;
    logic          err;

    modport master (
        input  instr_valid, instr, mov_done, alu_done, jmp_done, resume,
        output fetch_req, mov_str, alu_str, jmp_str, op_code, instr_q, busy, halted, err
    );

    modport slave (
        output instr_valid, instr, mov_done, alu_done, jmp_done, resume,
        input  fetch_req, mov_str, alu_str, jmp_str, op_code, instr_q, busy, halted, err
    );
endinterface

// File: rtl/exec_sequencer_op_class_decode.sv
// Combinational opcode -> execution-unit class; shared with the unit FSMs' self-checks.
module op_class_decode
    import exec_pkg::*;
(
    input  logic [3:0] opcode_i,
    output op_class_e  class_o
);

    always_comb begin
        class_o = CL_ILL;
        case (opcode_i)
            OP_MOVI, OP_MOV: class_o = CL_MOV;
            OP_JMP:          class_o = CL_JMP;
            OP_HALT:         class_o = CL_HALT;
            default:         if (!opcode_i[3]) class_o = CL_ALU;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Instruction sequencer: fetch, decode, strobe one execution unit, wait for its done.
// Optional WAIT watchdog enabled by defining EXEC_WATCHDOG_EN.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int IW     = 16,
    parameter int WD_MAX = 15
) (
    input logic                clk,
    input logic                reset,
    exec_sequencer_if.master   bus
);

    if (WD_MAX < 1) begin : g_bad_wd_max
        $error("exec_sequencer: WD_MAX must be at least 1");
    end

    state_e        state_q, state_d;
    logic [IW-1:0] instr_lat_q, instr_lat_d;
    op_class_e     cls;
    logic          done_sel;

    op_class_decode u_dec (
        .opcode_i (instr_lat_q[IW-1:IW-4]),
        .class_o  (cls)
    );

    // Only the unit selected by the latched opcode can end WAIT.
    always_comb begin
        done_sel = 1'b0;
        case (cls)
            CL_ALU:  done_sel = bus.alu_done;
            CL_MOV:  done_sel = bus.mov_done;
            CL_JMP:  done_sel = bus.jmp_done;
            default: done_sel = 1'b0;
        endcase
    end

`ifdef EXEC_WATCHDOG_EN
    localparam int WDW = $clog2(WD_MAX + 1);
    logic [WDW-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d     = state_q;
        instr_lat_d = instr_lat_q;
`ifdef EXEC_WATCHDOG_EN
        wd_d        = wd_q;
`endif
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    instr_lat_d = bus.instr;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CL_ALU, CL_MOV, CL_JMP: state_d = ST_ISSUE;
                    CL_HALT:                state_d = ST_HALTED;
                    default:                state_d = ST_ERR;
                endcase
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef EXEC_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            ST_WAIT: begin
                if (done_sel) begin
                    state_d = ST_FETCH;
                end
`ifdef EXEC_WATCHDOG_EN
                else begin
                    // Done has priority over expiry since it is tested first.
                    wd_d = wd_q + WDW'(1);
                    if (wd_d == WDW'(WD_MAX)) state_d = ST_ERR;
                end
`endif
            end
            ST_HALTED: if (bus.resume) state_d = ST_FETCH;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            instr_lat_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_lat_q <= instr_lat_d;
        end
    end

`ifdef EXEC_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`endif

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    assign bus.fetch_req = (state_q == ST_FETCH);
    assign bus.mov_str   = (state_q == ST_ISSUE) && (cls == CL_MOV);
    assign bus.alu_str   = (state_q == ST_ISSUE) && (cls == CL_ALU);
    assign bus.jmp_str   = (state_q == ST_ISSUE) && (cls == CL_JMP);
    assign bus.op_code   = instr_lat_q[IW-1:IW-4];
    assign bus.instr_q   = instr_lat_q;
    assign bus.busy      = (state_q == ST_DECODE) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus.halted    = (state_q == ST_HALTED);
    assign bus.err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer; watchdog cases compile in with EXEC_WATCHDOG_EN.
module tb_exec_sequencer;

    // Output vector order: {fetch_req, mov_str, alu_str, jmp_str, busy, halted, err}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_FETCH = 7'b1000000;
    localparam logic [6:0] O_BUSY  = 7'b0000100;
    localparam logic [6:0] O_MOV   = 7'b0100100;
    localparam logic [6:0] O_ALU   = 7'b0010100;
    localparam logic [6:0] O_JMP   = 7'b0001100;
    localparam logic [6:0] O_HALT  = 7'b0000010;
    localparam logic [6:0] O_ERR   = 7'b0000001;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    exec_sequencer_if #(.IW(16)) bus ();

    exec_sequencer #(.IW(16), .WD_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.fetch_req, bus.mov_str, bus.alu_str, bus.jmp_str, bus.busy, bus.halted, bus.err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; ends wait_cycles WAIT cycles after the strobe, ready for done to be driven.
    task automatic run_instr(input logic [15:0] ins, input logic [6:0] issue_pat, input int wait_cycles);
        logic [3:0] opc;
        opc             = ins[15:12];
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        tick();
        check("decode", 32'(outs()), 32'(O_BUSY));
        check("op_code", 32'(bus.op_code), 32'(opc));
        check("instr_q", 32'(bus.instr_q), 32'(ins));
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        tick();
        check("issue", 32'(outs()), 32'(issue_pat));
        for (int i = 0; i < wait_cycles; i++) begin
            if (i != 0 || 1'b1) tick();
            check("wait", 32'(outs()), 32'(O_BUSY));
            check("wait_opc", 32'(bus.op_code), 32'(opc));
        end
    endtask

    always @(negedge clk) begin
        if (!reset)
            check("strobe_onehot", 32'($countones({bus.mov_str, bus.alu_str, bus.jmp_str}) <= 1), 32'd1);
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.mov_done    = 1'b0;
        bus.alu_done    = 1'b0;
        bus.jmp_done    = 1'b0;
        bus.resume      = 1'b0;
        #2;
        check("reset_outs", 32'(outs()), 32'(O_IDLE));
        check("reset_instr_q", 32'(bus.instr_q), 32'h0);
        check("reset_op_code", 32'(bus.op_code), 32'h0);

        // Test 1: MOV A123 offered right at release
        repeat (2) @(posedge clk);
        #1;
        reset           = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'hA123;
        tick();
        check("t1_fetch", 32'(outs()), 32'(O_FETCH));
        run_instr(16'hA123, O_MOV, 4);
        bus.mov_done = 1'b1;
        tick();
        bus.mov_done = 1'b0;
        check("t1_back_fetch", 32'(outs()), 32'(O_FETCH));

        // Test 2: MOVI, ALU, JMP in order, done 4 cycles after each strobe
        run_instr(16'h9001, O_MOV, 4);
        bus.mov_done = 1'b1;
        tick();
        bus.mov_done = 1'b0;
        check("t2_movi_fetch", 32'(outs()), 32'(O_FETCH));
        run_instr(16'h3456, O_ALU, 4);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        check("t2_alu_fetch", 32'(outs()), 32'(O_FETCH));
        run_instr(16'hB0F0, O_JMP, 4);
        bus.jmp_done = 1'b1;
        tick();
        bus.jmp_done = 1'b0;
        check("t2_jmp_fetch", 32'(outs()), 32'(O_FETCH));

        // Test 3: foreign dones ignored while waiting on the ALU
        run_instr(16'h5ABC, O_ALU, 1);
        bus.mov_done = 1'b1;
        tick();
        bus.mov_done = 1'b0;
        check("t3_mov_done_ignored", 32'(outs()), 32'(O_BUSY));
        bus.jmp_done = 1'b1;
        tick();
        bus.jmp_done = 1'b0;
        check("t3_jmp_done_ignored", 32'(outs()), 32'(O_BUSY));
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        check("t3_alu_done_fetch", 32'(outs()), 32'(O_FETCH));

        // Test 4: HALT then resume, then illegal opcode 12
        bus.instr       = 16'hF00F;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("t4_halt_decode", 32'(outs()), 32'(O_BUSY));
        tick();
        check("t4_halted", 32'(outs()), 32'(O_HALT));
        tick();
        check("t4_halted_hold", 32'(outs()), 32'(O_HALT));
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("t4_resume_fetch", 32'(outs()), 32'(O_FETCH));
        bus.instr       = 16'hC123;
        bus.instr_valid = 1'b1;
        tick();
        check("t4_ill_decode", 32'(outs()), 32'(O_BUSY));
        tick();
        check("t4_err", 32'(outs()), 32'(O_ERR));
        bus.resume   = 1'b1;
        bus.mov_done = 1'b1;
        repeat (3) begin
            tick();
            check("t4_err_sticky", 32'(outs()), 32'(O_ERR));
        end
        bus.resume      = 1'b0;
        bus.mov_done    = 1'b0;
        bus.instr_valid = 1'b0;

        // Test 5: asynchronous reset during WAIT, late done after release
        reset = 1'b1;
        #1;
        check("t5_reset_err_clear", 32'(outs()), 32'(O_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("t5_fetch", 32'(outs()), 32'(O_FETCH));
        run_instr(16'hA000, O_MOV, 2);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_outs", 32'(outs()), 32'(O_IDLE));
        check("t5_async_instr_q", 32'(bus.instr_q), 32'h0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.mov_done = 1'b1;
        tick();
        check("t5_late_done_fetch", 32'(outs()), 32'(O_FETCH));
        tick();
        check("t5_late_done_ignored", 32'(outs()), 32'(O_FETCH));
        bus.mov_done = 1'b0;

`ifdef EXEC_WATCHDOG_EN
        // Test 6: watchdog expiry after 15 WAIT cycles, and done winning on the 15th
        run_instr(16'h1000, O_ALU, 15);
        tick();
        check("t6_wd_err", 32'(outs()), 32'(O_ERR));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("t6_fetch", 32'(outs()), 32'(O_FETCH));
        run_instr(16'h1000, O_ALU, 15);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        check("t6_done_wins", 32'(outs()), 32'(O_FETCH));
`else
        // Without the watchdog, WAIT holds indefinitely until the selected done
        run_instr(16'h1000, O_ALU, 30);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        check("t6_long_wait_fetch", 32'(outs()), 32'(O_FETCH));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
